// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, the write-responder state
// encoding and the byte-strobe merge helper used by the register bank.
package axi4lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_W,
      WAIT_AW,
      WRITE,
      RESP
   } state_t;

   // Widest supported data path; narrower callers zero-extend and truncate.
   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

   // Replace each byte of oldWord whose strobe bit is set with the same byte of newWord.
   function automatic logic [MAX_DATA_WIDTH-1:0] mergeBytes(
      input logic [MAX_DATA_WIDTH-1:0] oldWord,
      input logic [MAX_DATA_WIDTH-1:0] newWord,
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] result;
      result = oldWord;
      for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
         if (strb[i]) begin
            result[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// Register bank for the AXI4-Lite write responder: NUM_REGS words of
// DATA_WIDTH bits, byte-strobed writes, synchronous reset, flat read-out.
module axi4lite_regfile
   import axi4lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int NUM_REGS   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we,
   input  logic [$clog2(NUM_REGS)-1:0]    index,
   input  logic [DATA_WIDTH-1:0]          data,
   input  logic [STRB_WIDTH-1:0]          strb,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

   logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];
   logic [DATA_WIDTH-1:0] w_merged;

   // New value of the addressed word: old bytes kept where the strobe is clear.
   always_comb begin
      w_merged = DATA_WIDTH'(mergeBytes(MAX_DATA_WIDTH'(r_bank[index]),
                                        MAX_DATA_WIDTH'(data),
                                        MAX_STRB_WIDTH'(strb)));
   end

   // Bank storage: cleared on reset, one word updated per write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_bank[k] <= '0;
         end
      end else if (we) begin
         r_bank[index] <= w_merged;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs[k*DATA_WIDTH +: DATA_WIDTH] = r_bank[k];
   end

endmodule

// File: rtl/axi4lite_wr_slave.sv
// AXI4-Lite write-only responder. Accepts AW and W in either order or
// together, commits one beat into axi4lite_regfile, returns one B response.
// Optional macro AXI4L_WR_SLAVE_ADDR_CHECK_EN: reject addresses below the
// base, misaligned, or beyond the bank with SLVERR and no register update.
module axi4lite_wr_slave
   import axi4lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                    NUM_REGS   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic                           AWVALID,
   output logic                           AWREADY,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [STRB_WIDTH-1:0]          WSTRB,
   input  logic                           WVALID,
   output logic                           WREADY,
   output logic                           BVALID,
   input  logic                           BREADY,
   output logic [1:0]                     BRESP,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
   output logic                           wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0]    wr_index
);

   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int IDX_W    = $clog2(NUM_REGS);

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_WIDTH-1:0] r_awAddr;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRB_WIDTH-1:0] r_wStrb;
   resp_t                 r_bResp;

   logic                  w_awHs;
   logic                  w_wHs;
   logic [ADDR_WIDTH-1:0] w_offset;
   logic [IDX_W-1:0]      w_index;
   logic                  w_addrOk;
   logic                  w_regWe;
   logic                  w_unused;

   assign w_awHs   = AWVALID && AWREADY;
   assign w_wHs    = WVALID && WREADY;
   assign w_offset = r_awAddr - BASE_ADDR;
   assign w_index  = w_offset[ADDR_LSB +: IDX_W];
   assign w_unused = ^w_offset;
   assign BRESP    = r_bResp;

`ifdef AXI4L_WR_SLAVE_ADDR_CHECK_EN
   logic [ADDR_WIDTH-1:0] w_wordIdx;
   assign w_wordIdx = w_offset >> ADDR_LSB;
   assign w_addrOk  = (r_awAddr >= BASE_ADDR)
                   && (r_awAddr[ADDR_LSB-1:0] == '0)
                   && (w_wordIdx < ADDR_WIDTH'(NUM_REGS));
`else
   assign w_addrOk = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state: collect AW and W in any order, one write cycle, then hold the response.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_awHs && w_wHs) begin
               w_nextState = WRITE;
            end else if (w_awHs) begin
               w_nextState = WAIT_W;
            end else if (w_wHs) begin
               w_nextState = WAIT_AW;
            end
         end
         WAIT_W: begin
            if (w_wHs) begin
               w_nextState = WRITE;
            end
         end
         WAIT_AW: begin
            if (w_awHs) begin
               w_nextState = WRITE;
            end
         end
         WRITE: begin
            w_nextState = RESP;
         end
         RESP: begin
            if (BREADY) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; readies are held low while reset is asserted.
   always_comb begin
      AWREADY  = 1'b0;
      WREADY   = 1'b0;
      BVALID   = 1'b0;
      wr_pulse = 1'b0;
      wr_index = '0;
      w_regWe  = 1'b0;
      unique case (r_state)
         IDLE: begin
            AWREADY = !rst;
            WREADY  = !rst;
         end
         WAIT_W: begin
            WREADY = !rst;
         end
         WAIT_AW: begin
            AWREADY = !rst;
         end
         WRITE: begin
            w_regWe  = w_addrOk;
            wr_pulse = w_addrOk;
            wr_index = w_addrOk ? w_index : '0;
         end
         RESP: begin
            BVALID = 1'b1;
         end
         default: begin
            AWREADY = 1'b0;
         end
      endcase
   end

   // Capture address and data on their handshakes; settle the response during WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_awAddr <= '0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bResp  <= RESP_OKAY;
      end else begin
         if (w_awHs) begin
            r_awAddr <= AWADDR;
         end
         if (w_wHs) begin
            r_wData <= WDATA;
            r_wStrb <= WSTRB;
         end
         if (r_state == WRITE) begin
            r_bResp <= w_addrOk ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   axi4lite_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (w_regWe),
      .index (w_index),
      .data  (r_wData),
      .strb  (r_wStrb),
      .regs  (regs)
   );

endmodule

// File: tb/tb_axi4lite_wr_slave.sv
// Self-checking bench for axi4lite_wr_slave: table of directed write
// transactions plus hand-written backpressure and mid-transaction reset.
module tb_axi4lite_wr_slave;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = 4;
   localparam int NUM_REGS   = 4;
   localparam int NUM_VECS   = 8;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [ADDR_WIDTH-1:0]          AWADDR;
   logic                           AWVALID;
   logic                           AWREADY;
   logic [DATA_WIDTH-1:0]          WDATA;
   logic [STRB_WIDTH-1:0]          WSTRB;
   logic                           WVALID;
   logic                           WREADY;
   logic                           BVALID;
   logic                           BREADY;
   logic [1:0]                     BRESP;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs;
   logic                           wr_pulse;
   logic [1:0]                     wr_index;

   int numChecks = 0;
   int numErrors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awDelay;
      int          wDelay;
      int          regIdx;
      logic [31:0] expReg;
      logic        expPulse;
      logic [1:0]  expResp;
   } vec_t;

   vec_t vecs [NUM_VECS];

   always #5 clk = ~clk;

   axi4lite_wr_slave #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (32'h0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .AWADDR   (AWADDR),
      .AWVALID  (AWVALID),
      .AWREADY  (AWREADY),
      .WDATA    (WDATA),
      .WSTRB    (WSTRB),
      .WVALID   (WVALID),
      .WREADY   (WREADY),
      .BVALID   (BVALID),
      .BREADY   (BREADY),
      .BRESP    (BRESP),
      .regs     (regs),
      .wr_pulse (wr_pulse),
      .wr_index (wr_index)
   );

   function automatic logic [31:0] regWord(input int k);
      return regs[k*32 +: 32];
   endfunction

   // Compare one observed value against its expected value and log a failure.
   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Run one transaction from the table: staggered AW/W, then WRITE and RESP cycles.
   task automatic applyStimulus(input vec_t v, input int n);
      bit    awDone;
      bit    wDone;
      bit    awHs;
      bit    wHs;
      int    c;
      string tag;
      awDone = 1'b0;
      wDone  = 1'b0;
      c      = 0;
      tag    = $sformatf("v%0d", n);
      while (!(awDone && wDone)) begin
         if (c > 20) begin
            numChecks++;
            numErrors++;
            $display("[TB] FAIL %s handshake timeout: got no completion, expected both handshakes", tag);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            return;
         end
         AWADDR  = v.addr;
         WDATA   = v.data;
         WSTRB   = v.strb;
         AWVALID = !awDone && (c >= v.awDelay);
         WVALID  = !wDone && (c >= v.wDelay);
         #1;
         checkOutput({tag, " awready"}, AWREADY, !awDone);
         checkOutput({tag, " wready"}, WREADY, !wDone);
         awHs = AWVALID && AWREADY;
         wHs  = WVALID && WREADY;
         @(negedge clk);
         if (awHs) awDone = 1'b1;
         if (wHs) wDone = 1'b1;
         c++;
      end
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      AWADDR  = '1;
      WDATA   = '1;
      WSTRB   = '1;
      #1;
      checkOutput({tag, " wr_pulse"}, wr_pulse, v.expPulse);
      checkOutput({tag, " wr_index"}, wr_index, v.expPulse ? 2'(v.regIdx) : 2'd0);
      checkOutput({tag, " bvalid in write"}, BVALID, 1'b0);
      checkOutput({tag, " readies in write"}, {AWREADY, WREADY}, 2'b00);
      @(negedge clk);
      #1;
      checkOutput({tag, " bvalid"}, BVALID, 1'b1);
      checkOutput({tag, " bresp"}, BRESP, v.expResp);
      checkOutput({tag, " reg"}, regWord(v.regIdx), v.expReg);
      checkOutput({tag, " pulse after"}, wr_pulse, 1'b0);
      @(negedge clk);
      #1;
      checkOutput({tag, " bvalid drop"}, BVALID, 1'b0);
      checkOutput({tag, " readies idle"}, {AWREADY, WREADY}, 2'b11);
   endtask

   initial begin
      vecs[0] = '{32'h4, 32'hDEADFEED, 4'hF, 0, 0, 1, 32'hDEADFEED, 1'b1, 2'b00};
      vecs[1] = '{32'h8, 32'h12345678, 4'hF, 0, 3, 2, 32'h12345678, 1'b1, 2'b00};
      vecs[2] = '{32'hC, 32'hA5A5A5A5, 4'hF, 4, 0, 3, 32'hA5A5A5A5, 1'b1, 2'b00};
      vecs[3] = '{32'h0, 32'h11223344, 4'hF, 0, 0, 0, 32'h11223344, 1'b1, 2'b00};
      vecs[4] = '{32'h0, 32'hAABBCCDD, 4'h5, 0, 0, 0, 32'h11BB33DD, 1'b1, 2'b00};
      vecs[5] = '{32'h4, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 32'hDEADFEED, 1'b1, 2'b00};
`ifdef AXI4L_WR_SLAVE_ADDR_CHECK_EN
      vecs[6] = '{32'h10, 32'h0000CAFE, 4'hF, 0, 0, 0, 32'h11BB33DD, 1'b0, 2'b10};
      vecs[7] = '{32'h6, 32'h55667788, 4'h3, 1, 0, 1, 32'hDEADFEED, 1'b0, 2'b10};
`else
      vecs[6] = '{32'h10, 32'h0000CAFE, 4'hF, 0, 0, 0, 32'h0000CAFE, 1'b1, 2'b00};
      vecs[7] = '{32'h6, 32'h55667788, 4'h3, 1, 0, 1, 32'hDEADF788 & 32'hFFFF0000 | 32'h00007788, 1'b1, 2'b00};
`endif

      rst     = 1'b1;
      AWADDR  = '0;
      AWVALID = 1'b0;
      WDATA   = '0;
      WSTRB   = '0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset readies", {AWREADY, WREADY}, 2'b00);
      checkOutput("reset bvalid", BVALID, 1'b0);
      checkOutput("reset bresp", BRESP, 2'b00);
      checkOutput("reset pulse", {wr_pulse, wr_index}, 3'b000);
      checkOutput("reset regs", regs, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("post-reset readies", {AWREADY, WREADY}, 2'b11);

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Backpressure: response held for 5 cycles, next AW waits for the B handshake.
      BREADY  = 1'b0;
      AWADDR  = 32'h8;
      WDATA   = 32'h0BADF00D;
      WSTRB   = 4'hF;
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      #1;
      checkOutput("bp idle readies", {AWREADY, WREADY}, 2'b11);
      @(negedge clk);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      #1;
      checkOutput("bp pulse", {wr_pulse, wr_index}, 3'b110);
      AWVALID = 1'b1;
      AWADDR  = 32'hC;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("bp hold %0d bvalid/bresp", i), {BVALID, BRESP}, 3'b100);
         checkOutput($sformatf("bp hold %0d readies", i), {AWREADY, WREADY}, 2'b00);
      end
      checkOutput("bp reg2", regWord(2), 32'h0BADF00D);
      BREADY = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("bp after B readies", {AWREADY, WREADY}, 2'b11);
      checkOutput("bp after B bvalid", BVALID, 1'b0);
      @(negedge clk);
      AWVALID = 1'b0;
      #1;
      checkOutput("bp next aw accepted", {AWREADY, WREADY}, 2'b01);
      WVALID = 1'b1;
      WDATA  = 32'h00000077;
      WSTRB  = 4'h1;
      @(negedge clk);
      WVALID = 1'b0;
      #1;
      checkOutput("bp next pulse", {wr_pulse, wr_index}, 3'b111);
      @(negedge clk);
      #1;
      checkOutput("bp next reg3", regWord(3), 32'hA5A5A577);
      checkOutput("bp next bvalid", BVALID, 1'b1);
      @(negedge clk);
      #1;

      // Reset while waiting for W: latched address must be forgotten.
      AWVALID = 1'b1;
      AWADDR  = 32'h4;
      @(negedge clk);
      AWVALID = 1'b0;
      #1;
      checkOutput("rst wait_w readies", {AWREADY, WREADY}, 2'b01);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst mid regs", regs, 128'h0);
      checkOutput("rst mid outputs", {AWREADY, WREADY, BVALID, BRESP, wr_pulse}, 6'b000000);
      rst    = 1'b0;
      WVALID = 1'b1;
      WDATA  = 32'hFFFFFFFF;
      WSTRB  = 4'hF;
      #1;
      checkOutput("rst back to idle", {AWREADY, WREADY}, 2'b11);
      @(negedge clk);
      WVALID = 1'b0;
      #1;
      checkOutput("rst lone W pulse", wr_pulse, 1'b0);
      checkOutput("rst lone W readies", {AWREADY, WREADY}, 2'b10);
      @(negedge clk);
      #1;
      checkOutput("rst lone W no commit", {wr_pulse, BVALID}, 2'b00);
      checkOutput("rst lone W regs", regs, 128'h0);

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
